dff_bank_ctrl: RTL
==================

DFF_BANK_CTRL -- requirements
Module: dff_bank_ctrl

Interface
REQ-001 SHALL provide parameter N_CELLS, default 8, giving the number of controlled register cells.
REQ-002 SHALL provide parameter SR_PULSE, default 2, giving the cycles cell_sr is held high (legal range 1..15).
REQ-003 SHALL provide parameter CE_GAP, default 1, giving the cycles with sr=0 and ce=0 after an SR pulse (legal range 1..15).
REQ-004 SHALL have ports as follows; the single clock is clk and reset is rst, which is synchronous and active-high:
- clk  in  1  clock; all state changes on its rising edge.
- rst  in  1  synchronous active-high reset.
- cfg_wr  in  1  write cfg_cbit into the configuration register.
- cfg_cbit  in  2  cell mode: bit1 selects set (1) or reset (0); bit0 is the sync-mode value.
- cfg_err  out  1  one-cycle pulse when cfg_wr is dropped.
- cmd_valid  in  1  command request.
- cmd_ready  out  1  controller can accept a command.
- cmd_op  in  2  00 reserved, 01 SET_RESET, 10 CAPTURE, 11 SR_THEN_CAPTURE.
- cmd_mask  in  N_CELLS  cells enabled for capture.
- d_in  in  N_CELLS  capture data.
- cell_d  out  N_CELLS  data to cells.
- cell_ce  out  N_CELLS  per-cell clock enable.
- cell_sr  out  1  shared set/reset strobe.
- cell_cbit  out  2  shared mode bits.
- cell_q  in  N_CELLS  cell outputs.
- q_out  out  N_CELLS  sampled cell values.
- busy  out  1  high whenever the FSM is not in IDLE.
- done  out  1  one-cycle completion pulse.
- cmd_err  out  1  one-cycle pulse on a reserved op.

Function
REQ-005 SHALL implement the FSM states IDLE, SR_ASSERT, SR_GAP, CAPTURE, SAMPLE and DONE.
REQ-006 SHALL drive cmd_ready=1 only in IDLE and never in a cycle where rst=1.
REQ-007 SHALL accept a command on a rising edge where cmd_valid and cmd_ready are both 1; cmd_op, cmd_mask and d_in SHALL be registered at that edge (cycle T).
REQ-008 SHALL latch cfg_cbit into cell_cbit on cfg_wr only in IDLE.
REQ-009 SHALL ignore cfg_wr outside IDLE, leaving cell_cbit unchanged, and pulse cfg_err for 1 cycle.
REQ-010 SHALL, when cfg_wr and a command accept occur on the same edge, apply the new cbit first so the command uses it.
REQ-011 SHALL handle SET_RESET as follows:
- cell_sr=1 and cell_ce=0 for cycles T+1..T+SR_PULSE (SR_ASSERT).
- then cell_sr=0 and cell_ce=0 for CE_GAP cycles (SR_GAP).
- then DONE with done=1 for 1 cycle at T+SR_PULSE+CE_GAP+1.
REQ-012 SHALL handle CAPTURE as follows:
- cycle T+1: cell_d=registered d_in and cell_ce=registered mask (CAPTURE).
- cycle T+2 (SAMPLE): q_out bits where mask=1 take cell_q at the end of the cycle; unmasked bits hold.
- cycle T+3: DONE, done=1.
REQ-013 SHALL run SR_THEN_CAPTURE as the SET_RESET sequence followed directly by the CAPTURE sequence, without passing through IDLE; done SHALL pulse once at T+SR_PULSE+CE_GAP+3.
REQ-014 SHALL, for cmd_op=00, go to DONE with done=1 and cmd_err=1 together at T+1, with no activity on cell_sr or cell_ce.
REQ-015 SHALL still execute CAPTURE with cmd_mask=0: no ce bits asserted, q_out unchanged, done pulsed.
REQ-016 SHALL return from DONE to IDLE after exactly 1 cycle; back-to-back commands SHALL be accepted no earlier than the cycle after DONE.
REQ-017 SHALL drive cell_ce=0 in every state except CAPTURE, and drive cell_sr=1 only in SR_ASSERT.
REQ-018 SHALL hold cell_d at its last value outside CAPTURE.
REQ-019 SHALL count SR_ASSERT and SR_GAP with a 4-bit down-counter that is reloaded on each state entry and never wraps.

Reset
REQ-020 SHALL, with rst=1 at an edge, set the following at the next cycle:
- FSM=IDLE, cell_sr=0, cell_ce=0, cell_d=0, cell_cbit=2'b00, q_out=0.
- done=0, cmd_err=0, cfg_err=0, busy=0.
REQ-021 SHALL abort any sequence in progress when rst is asserted mid-operation, issuing no done pulse and resetting all outputs per REQ-020.
REQ-022 SHALL give rst priority over cfg_wr and command accept on the same edge.

Verification
REQ-023 SHALL be covered by a bench running the following directed scenarios:
- cfg_wr cbit=2'b11, then SET_RESET at T=10 with SR_PULSE=2 and CE_GAP=1 -> cell_sr high in cycles 11-12, low in cycle 13, done at 14, cell_cbit=2'b11 throughout.
- CAPTURE with d_in=8'hA5 and mask=8'h0F, cell model echoing d on ce -> cell_ce=8'h0F for 1 cycle, q_out=8'h05 at T+3, done=1 at T+3.
- cmd_op=00 -> done and cmd_err both high at T+1, cell_sr=0, cell_ce=0.
- cfg_wr during SR_ASSERT -> cfg_err pulse, cell_cbit unchanged.
- rst asserted in cycle T+1 of SR_THEN_CAPTURE -> next cycle cell_sr=0, busy=0, and no done ever follows.
- Simultaneous cfg_wr 2'b10 and CAPTURE accept -> cell_cbit=2'b10 at T+1, and cmd_ready=0 until the cycle after done.

Source files
------------

// File: rtl/dff_bank_ctrl_if.sv
// -----------------------------------------------------------------------------
// dff_bank_ctrl_if
// Host-side command/configuration bus of the register-bank sequencer.
//
// Signals
//   cfg_wr, cfg_cbit   host -> ctrl   configuration write of the shared mode bits
//   cfg_err            ctrl -> host   one-cycle pulse when a cfg write is dropped
//   cmd_valid, cmd_op  host -> ctrl   command request and opcode
//   cmd_mask, d_in     host -> ctrl   per-cell capture enable and capture data
//   cmd_ready          ctrl -> host   controller idle and able to accept
//   q_out              ctrl -> host   sampled cell values
//   busy, done         ctrl -> host   sequence in progress / completion pulse
//   cmd_err            ctrl -> host   one-cycle pulse on a reserved opcode
//
// Modports
//   master : the host issuing commands
//   slave  : the controller
// -----------------------------------------------------------------------------
interface dff_bank_ctrl_if #(
  parameter int N_CELLS = 8
);
  logic               cfg_wr;
  logic [1:0]         cfg_cbit;
  logic               cfg_err;
  logic               cmd_valid;
  logic               cmd_ready;
  logic [1:0]         cmd_op;
  logic [N_CELLS-1:0] cmd_mask;
  logic [N_CELLS-1:0] d_in;
  logic [N_CELLS-1:0] q_out;
  logic               busy;
  logic               done;
  logic               cmd_err;

  modport master (
    output cfg_wr, cfg_cbit, cmd_valid, cmd_op, cmd_mask, d_in,
    input  cfg_err, cmd_ready, q_out, busy, done, cmd_err
  );

  modport slave (
    input  cfg_wr, cfg_cbit, cmd_valid, cmd_op, cmd_mask, d_in,
    output cfg_err, cmd_ready, q_out, busy, done, cmd_err
  );
endinterface

// File: rtl/dff_bank_ctrl.sv
// -----------------------------------------------------------------------------
// dff_bank_ctrl
// Sequencer for a bank of configurable register cells. It strobes the shared
// set/reset line, opens per-cell clock enables to load data, samples the cell
// outputs back, and reports completion to the host.
//
// Parameters
//   N_CELLS   number of controlled cells
//   SR_PULSE  cycles cell_sr is held high (1..15)
//   CE_GAP    quiet cycles (sr=0, ce=0) after the SR pulse (1..15)
//
// Ports
//   clk        clock, all state changes on the rising edge
//   rst        synchronous active-high reset
//   host       command/config bus (slave side)
//   cell_d     data presented to the cells
//   cell_ce    per-cell clock enable
//   cell_sr    shared set/reset strobe
//   cell_cbit  shared mode bits (bit1: set/reset select, bit0: sync mode)
//   cell_q     cell outputs
//
// State        | meaning
// -------------+--------------------------------------------------------------
// S_IDLE       | waiting for a command; only state that accepts cmd or cfg
// S_SR_ASSERT  | cell_sr high for SR_PULSE cycles
// S_SR_GAP     | sr and ce low for CE_GAP cycles before anything else
// S_CAPTURE    | cell_d = latched data, cell_ce = latched mask for one cycle
// S_SAMPLE     | masked q_out bits load cell_q at the end of this cycle
// S_DONE       | done pulse, back to idle next cycle
// -----------------------------------------------------------------------------
module dff_bank_ctrl #(
  parameter int N_CELLS  = 8,
  parameter int SR_PULSE = 2,
  parameter int CE_GAP   = 1
) (
  input  logic               clk,
  input  logic               rst,
  dff_bank_ctrl_if.slave     host,
  output logic [N_CELLS-1:0] cell_d,
  output logic [N_CELLS-1:0] cell_ce,
  output logic               cell_sr,
  output logic [1:0]         cell_cbit,
  input  logic [N_CELLS-1:0] cell_q
);

  localparam logic [1:0] OP_SR     = 2'b01;
  localparam logic [1:0] OP_CAP    = 2'b10;
  localparam logic [1:0] OP_SR_CAP = 2'b11;

  // Counter reload values: the counter reaches zero in the last cycle of
  // the state, so it is loaded with length-1 on entry.
  localparam logic [3:0] SR_LOAD  = 4'(SR_PULSE - 1);
  localparam logic [3:0] GAP_LOAD = 4'(CE_GAP - 1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_SR_ASSERT,
    S_SR_GAP,
    S_CAPTURE,
    S_SAMPLE,
    S_DONE
  } state_t;

  state_t             r_state;
  logic [3:0]         r_cnt;
  logic [1:0]         r_op;
  logic [N_CELLS-1:0] r_mask;
  logic [N_CELLS-1:0] r_d;
  logic [N_CELLS-1:0] r_cell_d;
  logic [N_CELLS-1:0] r_cell_ce;
  logic               r_cell_sr;
  logic [1:0]         r_cbit;
  logic [N_CELLS-1:0] r_q;
  logic               r_done;
  logic               r_cmd_err;
  logic               r_cfg_err;

  logic w_idle;
  logic w_ready;

  assign w_idle  = (r_state == S_IDLE);
  // Ready is gated by rst so a command can never look accepted in a reset cycle.
  assign w_ready = w_idle && !rst;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state   <= S_IDLE;
      r_cnt     <= '0;
      r_op      <= '0;
      r_mask    <= '0;
      r_d       <= '0;
      r_cell_d  <= '0;
      r_cell_ce <= '0;
      r_cell_sr <= 1'b0;
      r_cbit    <= 2'b00;
      r_q       <= '0;
      r_done    <= 1'b0;
      r_cmd_err <= 1'b0;
      r_cfg_err <= 1'b0;
    end else begin
      r_done    <= 1'b0;
      r_cmd_err <= 1'b0;
      r_cfg_err <= 1'b0;

      // A write landing on the accept edge is taken here as well, so the
      // command that starts on the same edge already sees the new mode bits.
      if (host.cfg_wr) begin
        if (w_idle) begin
          r_cbit <= host.cfg_cbit;
        end else begin
          r_cfg_err <= 1'b1;
        end
      end

      case (r_state)
        S_IDLE: begin
          if (host.cmd_valid) begin
            r_op   <= host.cmd_op;
            r_mask <= host.cmd_mask;
            r_d    <= host.d_in;
            case (host.cmd_op)
              OP_SR, OP_SR_CAP: begin
                r_state   <= S_SR_ASSERT;
                r_cell_sr <= 1'b1;
                r_cnt     <= SR_LOAD;
              end
              OP_CAP: begin
                r_state   <= S_CAPTURE;
                r_cell_d  <= host.d_in;
                r_cell_ce <= host.cmd_mask;
              end
              default: begin
                // Reserved opcode: report and finish without touching the cells.
                r_state   <= S_DONE;
                r_done    <= 1'b1;
                r_cmd_err <= 1'b1;
              end
            endcase
          end
        end

        S_SR_ASSERT: begin
          if (r_cnt == 4'd0) begin
            r_state   <= S_SR_GAP;
            r_cell_sr <= 1'b0;
            r_cnt     <= GAP_LOAD;
          end else begin
            r_cnt <= r_cnt - 4'd1;
          end
        end

        S_SR_GAP: begin
          if (r_cnt == 4'd0) begin
            if (r_op == OP_SR_CAP) begin
              r_state   <= S_CAPTURE;
              r_cell_d  <= r_d;
              r_cell_ce <= r_mask;
            end else begin
              r_state <= S_DONE;
              r_done  <= 1'b1;
            end
          end else begin
            r_cnt <= r_cnt - 4'd1;
          end
        end

        S_CAPTURE: begin
          r_state   <= S_SAMPLE;
          r_cell_ce <= '0;
        end

        S_SAMPLE: begin
          // Cells loaded on the CAPTURE edge are now visible on cell_q.
          r_q     <= (r_q & ~r_mask) | (cell_q & r_mask);
          r_state <= S_DONE;
          r_done  <= 1'b1;
        end

        S_DONE: begin
          r_state <= S_IDLE;
        end

        default: begin
          r_state   <= S_IDLE;
          r_cell_sr <= 1'b0;
          r_cell_ce <= '0;
        end
      endcase
    end
  end

  assign host.cmd_ready = w_ready;
  assign host.busy      = !w_idle;
  assign host.done      = r_done;
  assign host.cmd_err   = r_cmd_err;
  assign host.cfg_err   = r_cfg_err;
  assign host.q_out     = r_q;

  assign cell_d    = r_cell_d;
  assign cell_ce   = r_cell_ce;
  assign cell_sr   = r_cell_sr;
  assign cell_cbit = r_cbit;

endmodule
